dat_mem_stk: RTL and testbench

Parametrised data memory with a built-in hardware stack region. It serves normal random-access loads and stores, plus push and pop with a hardware-managed stack pointer, overflow/underflow detection and a write-complete pulse. It sits beside the datapath as the processor's data memory and replaces the fixed 8x256 array.

---
 rtl/dat_mem_stk.sv | 192 +++++++++++++++++++
 tb/tb_dat_mem_stk.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dat_mem_stk.sv
// -----------------------------------------------------------------------------
// dat_mem_stk
//   Data memory of 2**AW words of DW bits with a hardware stack carved out of
//   the top of the address space. The stack grows downward from STK_BASE and
//   holds at most STK_DEPTH entries. sp always names the next free slot.
//
//   Optional build macro: DAT_MEM_STK_RDREG_EN
//     defined   -> dat_out is registered (one-cycle latency, read-before-write,
//                  resets to 0)
//     undefined -> dat_out is combinational core[addr]
//
// Ports
//   clk        in   single clock, all state changes on posedge
//   rst_n      in   synchronous active-low reset
//   dat_in     in   DW  store / push data
//   wr_en      in   random-access write enable
//   addr       in   AW  random-access address
//   push       in   push dat_in onto the stack
//   pop        in   pop the top of the stack
//   dat_out    out  DW  random-access read data core[addr]
//   done       out  pulse the cycle after an accepted write or push
//   stk_out    out  DW  data of the last accepted pop (held)
//   stk_vld    out  pulse the cycle after an accepted pop
//   sp         out  AW  stack pointer (next free slot)
//   stk_full   out  entry count == STK_DEPTH
//   stk_empty  out  entry count == 0
//   err        out  sticky overflow / underflow / push+pop collision flag
//
// Handshake: there is no back-pressure. A request is accepted when it is
// sampled high at a posedge and is legal in the current state; acceptance is
// reported by a single-cycle pulse (done or stk_vld) in the following cycle.
// Rejected stack requests set err instead and produce no pulse.
// -----------------------------------------------------------------------------
module dat_mem_stk #(
  parameter int DW        = 8,
  parameter int AW        = 8,
  parameter int STK_DEPTH = 16,
  parameter int STK_BASE  = 2**AW - 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] dat_in,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic          push,
  input  logic          pop,
  output logic [DW-1:0] dat_out,
  output logic          done,
  output logic [DW-1:0] stk_out,
  output logic          stk_vld,
  output logic [AW-1:0] sp,
  output logic          stk_full,
  output logic          stk_empty,
  output logic          err
);

  localparam int            CW      = $clog2(STK_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(STK_DEPTH);
  localparam logic [AW-1:0] BASE_C  = AW'(STK_BASE);

  // Storage array: never reset, contents survive rst_n.
  logic [DW-1:0] core [2**AW];

  // Registered state
  logic [AW-1:0] sp_q,      sp_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic          done_q,    done_d;
  logic          stk_vld_q, stk_vld_d;
  logic [DW-1:0] stk_out_q, stk_out_d;
  logic          full_q,    full_d;
  logic          empty_q,   empty_d;
  logic          err_q,     err_d;

  // Request decode
  logic          push_ok;
  logic          pop_ok;
  logic          wr_ok;
  logic          bad_req;
  logic [AW-1:0] sp_plus1;

  // Memory write port
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;

  assign sp_plus1 = sp_q + AW'(1);

  always_comb begin
    // A lone push/pop is legal only when the stack has room / data.
    push_ok = push & ~pop & ~full_q;
    pop_ok  = pop & ~push & ~empty_q;
    // Any stack request wins over a random-access write.
    wr_ok   = wr_en & ~push & ~pop;
    // Overflow, underflow and push+pop collision all flag an error.
    bad_req = (push & pop) | (push & ~pop & full_q) | (pop & ~push & empty_q);
  end

  always_comb begin
    sp_d      = sp_q;
    cnt_d     = cnt_q;
    stk_out_d = stk_out_q;
    done_d    = 1'b0;
    stk_vld_d = 1'b0;
    err_d     = err_q | bad_req;
    mem_we    = 1'b0;
    mem_wa    = addr;
    mem_wd    = dat_in;

    if (push_ok) begin
      mem_we = 1'b1;
      mem_wa = sp_q;
      sp_d   = sp_q - AW'(1);
      cnt_d  = cnt_q + CW'(1);
      done_d = 1'b1;
    end else if (pop_ok) begin
      // The top entry lives one slot above the next-free pointer.
      sp_d      = sp_plus1;
      cnt_d     = cnt_q - CW'(1);
      stk_out_d = core[sp_plus1];
      stk_vld_d = 1'b1;
    end else if (wr_ok) begin
      mem_we = 1'b1;
      done_d = 1'b1;
    end

    full_d  = (cnt_d == DEPTH_C);
    empty_d = (cnt_d == '0);

    // Reset suppresses any write requested in the same cycle.
    if (!rst_n) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_q      <= BASE_C;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      stk_vld_q <= 1'b0;
      stk_out_q <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      sp_q      <= sp_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      stk_vld_q <= stk_vld_d;
      stk_out_q <= stk_out_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      core[mem_wa] <= mem_wd;
    end
  end

`ifdef DAT_MEM_STK_RDREG_EN
  // Registered read: samples the array before this edge's write lands.
  logic [DW-1:0] dat_out_q, dat_out_d;

  always_comb begin
    dat_out_d = core[addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dat_out_q <= '0;
    end else begin
      dat_out_q <= dat_out_d;
    end
  end

  assign dat_out = dat_out_q;
`else
  assign dat_out = core[addr];
`endif

  assign sp        = sp_q;
  assign done      = done_q;
  assign stk_out   = stk_out_q;
  assign stk_vld   = stk_vld_q;
  assign stk_full  = full_q;
  assign stk_empty = empty_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dat_mem_stk.sv
// -----------------------------------------------------------------------------
// tb_dat_mem_stk
//   Directed steps followed by a randomized run against a reference model that
//   tracks memory contents in an array and the stack as an entry count.
// -----------------------------------------------------------------------------
module tb_dat_mem_stk;

  localparam int DW        = 8;
  localparam int AW        = 8;
  localparam int STK_DEPTH = 16;
  localparam int STK_BASE  = 255;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [DW-1:0] dat_in;
  logic          wr_en;
  logic [AW-1:0] addr;
  logic          push;
  logic          pop;
  logic [DW-1:0] dat_out;
  logic          done;
  logic [DW-1:0] stk_out;
  logic          stk_vld;
  logic [AW-1:0] sp;
  logic          stk_full;
  logic          stk_empty;
  logic          err;

  dat_mem_stk #(
    .DW(DW), .AW(AW), .STK_DEPTH(STK_DEPTH), .STK_BASE(STK_BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .dat_in(dat_in), .wr_en(wr_en), .addr(addr),
    .push(push), .pop(pop), .dat_out(dat_out), .done(done),
    .stk_out(stk_out), .stk_vld(stk_vld), .sp(sp), .stk_full(stk_full),
    .stk_empty(stk_empty), .err(err)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] m_mem [256];
  bit            m_known [256];
  int            m_cnt;
  bit            m_err;
  logic [DW-1:0] m_stk_out;
  bit            m_done;
  bit            m_vld;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then check every output.
  task automatic step(input bit r, input bit pu, input bit po, input bit we,
                      input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input string tag);
    int slot;
    rst_n = r; push = pu; pop = po; wr_en = we; addr = a; dat_in = d;
    m_done = 0;
    m_vld  = 0;
    if (!r) begin
      m_cnt = 0; m_err = 0; m_stk_out = '0;
    end else if (pu && po) begin
      m_err = 1;
    end else if (pu) begin
      if (m_cnt == STK_DEPTH) m_err = 1;
      else begin
        slot = STK_BASE - m_cnt;
        m_mem[slot] = d; m_known[slot] = 1;
        m_cnt++; m_done = 1;
      end
    end else if (po) begin
      if (m_cnt == 0) m_err = 1;
      else begin
        m_cnt--;
        m_stk_out = m_mem[STK_BASE - m_cnt];
        m_vld = 1;
      end
    end else if (we) begin
      m_mem[a] = d; m_known[a] = 1; m_done = 1;
    end
    @(posedge clk);
    #1;
    chk({tag, ".done"},      32'(done),      32'(m_done));
    chk({tag, ".stk_vld"},   32'(stk_vld),   32'(m_vld));
    chk({tag, ".stk_out"},   32'(stk_out),   32'(m_stk_out));
    chk({tag, ".sp"},        32'(sp),        32'(STK_BASE - m_cnt));
    chk({tag, ".stk_full"},  32'(stk_full),  32'(m_cnt == STK_DEPTH));
    chk({tag, ".stk_empty"}, 32'(stk_empty), 32'(m_cnt == 0));
    chk({tag, ".err"},       32'(err),       32'(m_err));
  endtask

  // Idle cycle with addr held: valid for both combinational and registered read.
  task automatic rd(input logic [AW-1:0] a, input string tag);
    step(1, 0, 0, 0, a, '0, tag);
    if (m_known[a]) chk({tag, ".dat_out"}, 32'(dat_out), 32'(m_mem[a]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    logic [AW-1:0] ra;
    for (int i = 0; i < 256; i++) begin
      m_known[i] = 0;
      m_mem[i]   = '0;
    end
    m_cnt = 0; m_err = 0; m_stk_out = '0;
    rst_n = 0; push = 0; pop = 0; wr_en = 0; addr = '0; dat_in = '0;
    @(posedge clk);
    #1;

    // Reset state
    step(0, 0, 0, 0, 8'h00, 8'h00, "reset");

    // 1: random-access write and read back
    step(1, 0, 0, 1, 8'h10, 8'hA5, "t1_wr");
    rd(8'h10, "t1_rd");

    // 2: three pushes, two pops, bottom entry visible at 0xFF
    step(1, 1, 0, 0, 8'h00, 8'h11, "t2_push1");
    step(1, 1, 0, 0, 8'h00, 8'h22, "t2_push2");
    step(1, 1, 0, 0, 8'h00, 8'h33, "t2_push3");
    step(1, 0, 1, 0, 8'h00, 8'h00, "t2_pop1");
    step(1, 0, 1, 0, 8'h00, 8'h00, "t2_pop2");
    rd(8'hFF, "t2_rd");
    step(1, 0, 1, 0, 8'h00, 8'h00, "t2_pop3");

    // 3: fill to full, then overflow
    for (int i = 0; i < STK_DEPTH; i++)
      step(1, 1, 0, 0, 8'h00, 8'(8'h40 + i), "t3_fill");
    step(1, 1, 0, 0, 8'h00, 8'hEE, "t3_ovf");
    rd(8'hEF, "t3_rd");

    // 4: underflow from reset
    step(0, 0, 0, 0, 8'h00, 8'h00, "t4_rst");
    step(1, 0, 1, 0, 8'h00, 8'h00, "t4_unf");

    // 5: push beats wr_en; push+pop collision
    step(0, 0, 0, 0, 8'h00, 8'h00, "t5_rst");
    step(1, 0, 0, 1, 8'h20, 8'h77, "t5_wr");
    step(1, 1, 0, 1, 8'h20, 8'h5A, "t5_push_wr");
    rd(8'h20, "t5_rd20");
    rd(8'hFF, "t5_rdff");
    step(1, 1, 1, 0, 8'h00, 8'h99, "t5_pushpop");

    // 6: reset mid-stack with push held
    step(0, 0, 0, 0, 8'h00, 8'h00, "t6_rst0");
    step(1, 1, 0, 0, 8'h00, 8'hA1, "t6_push1");
    step(1, 1, 0, 0, 8'h00, 8'hB2, "t6_push2");
    step(1, 1, 0, 0, 8'h00, 8'hC3, "t6_push3");
    step(0, 1, 0, 0, 8'h00, 8'hDD, "t6_rst_push");
    rd(8'hFE, "t6_rdfe");
    rd(8'hFD, "t6_rdfd");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      r  = $urandom_range(0, 99);
      ra = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(8'hE8, 8'hFF))
                                       : 8'($urandom_range(0, 15));
      if (r < 2)       step(0, 0, 0, 0, ra, 8'($urandom), "rnd_rst");
      else if (r < 32) step(1, 1, 0, $urandom_range(0, 1), ra, 8'($urandom), "rnd_push");
      else if (r < 60) step(1, 0, 1, $urandom_range(0, 1), ra, 8'($urandom), "rnd_pop");
      else if (r < 63) step(1, 1, 1, 0, ra, 8'($urandom), "rnd_pushpop");
      else if (r < 80) step(1, 0, 0, 1, ra, 8'($urandom), "rnd_wr");
      else             rd(ra, "rnd_rd");
    end

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
